// File: rtl/spi_burst_ctrl.sv
// spi_burst_ctrl: TX/RX FIFO sequencer that issues back-to-back spi_master transfers with an inter-word gap.
// Defining SPI_BURST_XFER_CNT_EN adds the XferCnt completed-transfer counter output.
module spi_burst_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  En,
  input  logic                  TxWr,
  input  logic [DATA_WIDTH-1:0] TxWData,
  output logic                  TxFull,
  input  logic                  RxRd,
  output logic [DATA_WIDTH-1:0] RxRData,
  output logic                  RxEmpty,
  output logic                  TxOvf,
  output logic                  Busy,
  output logic                  MstStart,
  output logic [DATA_WIDTH-1:0] MstTxData,
  input  logic                  MstDone,
  input  logic [DATA_WIDTH-1:0] MstRxData
`ifdef SPI_BURST_XFER_CNT_EN
  ,
  output logic [15:0]           XferCnt
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, CAPTURE, GAP} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr, rx_cnt;
  logic [AW-1:0] rx_rnext;
  logic [DATA_WIDTH-1:0] rx_lat, rx_head_nx;
  logic [CW-1:0] gap_cnt;
  logic tx_empty, tx_full, rx_empty, rx_full, tx_push, tx_pop, rx_push, rx_pop, launch;

  always_comb begin
    tx_empty   = tx_wptr == tx_rptr;
    tx_full    = tx_wptr == {~tx_rptr[AW], tx_rptr[AW-1:0]};
    rx_empty   = rx_wptr == rx_rptr;
    rx_full    = rx_wptr == {~rx_rptr[AW], rx_rptr[AW-1:0]};
    rx_cnt     = rx_wptr - rx_rptr;
    rx_rnext   = rx_rptr[AW-1:0] + AW'(1);
    tx_push    = TxWr & ~tx_full;
    tx_pop     = state == LOAD;
    rx_push    = state == CAPTURE;
    rx_pop     = RxRd & ~rx_empty;
    launch     = En & ~tx_empty & ~rx_full;
    // Head register: next entry on pop, the captured word when it lands in an emptying FIFO, else hold
    rx_head_nx = rx_pop && rx_cnt > PW'(1) ? rx_mem[rx_rnext] :
                 rx_push && rx_cnt == PW'(rx_pop) ? rx_lat : RxRData;
  end

  assign TxFull   = tx_full;
  assign RxEmpty  = rx_empty;
  assign Busy     = state != IDLE;
  assign MstStart = state == START;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = launch ? LOAD : IDLE;
      LOAD:    state_nx = START;
      START:   state_nx = WAIT;
      WAIT:    state_nx = MstDone ? CAPTURE : WAIT;
      CAPTURE: state_nx = GAP_CYCLES > 0 ? GAP : IDLE;
      GAP:     state_nx = gap_cnt == '0 ? IDLE : GAP;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      tx_wptr   <= '0;
      tx_rptr   <= '0;
      rx_wptr   <= '0;
      rx_rptr   <= '0;
      TxOvf     <= 1'b0;
      MstTxData <= '0;
      RxRData   <= '0;
      rx_lat    <= '0;
      gap_cnt   <= '0;
    end else begin
      state <= state_nx;
      if (tx_push) tx_wptr <= tx_wptr + PW'(1);
      if (tx_pop) begin
        tx_rptr   <= tx_rptr + PW'(1);
        MstTxData <= tx_mem[tx_rptr[AW-1:0]];
      end
      if (TxWr && tx_full) TxOvf <= 1'b1;
      if (state == WAIT && MstDone) rx_lat <= MstRxData;
      if (rx_push) rx_wptr <= rx_wptr + PW'(1);
      if (rx_pop) rx_rptr <= rx_rptr + PW'(1);
      RxRData <= rx_head_nx;
      gap_cnt <= state == CAPTURE ? CW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0) : gap_cnt - CW'(state == GAP);
    end
  end

  always_ff @(posedge Clk) begin
    if (tx_push) tx_mem[tx_wptr[AW-1:0]] <= TxWData;
    if (rx_push) rx_mem[rx_wptr[AW-1:0]] <= rx_lat;
  end

`ifdef SPI_BURST_XFER_CNT_EN
  always_ff @(posedge Clk) begin
    if (Reset) XferCnt <= '0;
    else if (rx_push) XferCnt <= XferCnt + 16'd1;
  end
`endif
endmodule
